// File: rtl/md_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit.
package md_pkg;

    // Operation encoding on the op input
    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    // Control states: wait for start, iterate, then sign fix-up and result write
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } state_t;

endpackage

// File: rtl/md_negate.sv
// Conditional two's-complement negate, used for operand magnitudes and result signs.
module md_negate #(
    parameter int W = 32
) (
    input  logic [W-1:0] value,
    input  logic         neg,
    output logic [W-1:0] result
);

    // Pass through or negate depending on neg
    always_comb begin
        result = value;
        if (neg) begin
            result = ~value + W'(1);
        end
    end

endmodule

// File: rtl/md_unit.sv
// Iterative multiply/divide unit: one shift-add or restoring-divide step per cycle,
// with operand magnitudes taken up front and signs restored in a final FIX cycle.
module md_unit
    import md_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    localparam int W = WIDTH;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               is_div;
    logic               neg_res;   // product / quotient must be negated
    logic               neg_rem;   // remainder follows the dividend sign
    logic               b_zero;
    logic [W-1:0]       a_orig;    // original dividend, reported on divide by zero
    logic [W-1:0]       mag_b;
    // Multiply: {partial product, remaining multiplier bits}.
    // Divide:   {partial remainder, dividend bits shifting out / quotient bits shifting in}.
    logic [2*W-1:0]     acc;

    logic               op_signed;
    logic               op_is_div;
    logic [W-1:0]       mag_a_in;
    logic [W-1:0]       mag_b_in;
    logic [2*W-1:0]     prod_fix;
    logic [W-1:0]       quot_fix;
    logic [W-1:0]       rem_fix;

    logic [W:0]         mul_sum;
    logic [W:0]         div_shift;
    logic [W:0]         div_diff;
    logic [2*W-1:0]     acc_next;

    assign op_signed = (op == OP_MULT) || (op == OP_DIV);
    assign op_is_div = (op == OP_DIVU) || (op == OP_DIV);

    // Operand magnitudes for signed operations
    md_negate #(.W(W)) u_neg_a (
        .value  (a),
        .neg    (op_signed & a[W-1]),
        .result (mag_a_in)
    );

    md_negate #(.W(W)) u_neg_b (
        .value  (b),
        .neg    (op_signed & b[W-1]),
        .result (mag_b_in)
    );

    // Sign restoration of the finished results
    md_negate #(.W(2*W)) u_neg_prod (
        .value  (acc),
        .neg    (neg_res),
        .result (prod_fix)
    );

    md_negate #(.W(W)) u_neg_quot (
        .value  (acc[W-1:0]),
        .neg    (neg_res),
        .result (quot_fix)
    );

    md_negate #(.W(W)) u_neg_rem (
        .value  (acc[2*W-1:W]),
        .neg    (neg_rem),
        .result (rem_fix)
    );

    // One iteration step: shift-add for multiply, restoring subtract for divide.
    // A non-negative trial difference is always below 2^W, so bit W is the borrow.
    always_comb begin
        mul_sum   = {1'b0, acc[2*W-1:W]} + {1'b0, (acc[0] ? mag_b : {W{1'b0}})};
        div_shift = {acc[2*W-1:W], acc[W-1]};
        div_diff  = div_shift - {1'b0, mag_b};
        acc_next  = acc;
        if (!is_div) begin
            acc_next = {mul_sum, acc[W-1:1]};
        end else if (!b_zero) begin
            if (!div_diff[W]) begin
                acc_next = {div_diff[W-1:0], acc[W-2:0], 1'b1};
            end else begin
                acc_next = {div_shift[W-1:0], acc[W-2:0], 1'b0};
            end
        end
    end

    // Control FSM with registered busy/done/results
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            b_zero   <= 1'b0;
            a_orig   <= '0;
            mag_b    <= '0;
            acc      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        is_div   <= op_is_div;
                        neg_res  <= op_signed & (a[W-1] ^ b[W-1]);
                        neg_rem  <= op_signed & a[W-1];
                        b_zero   <= (b == '0);
                        a_orig   <= a;
                        mag_b    <= mag_b_in;
                        acc      <= {{W{1'b0}}, mag_a_in};
                        cnt      <= CNT_W'(W);
                        busy     <= 1'b1;
                        div_zero <= 1'b0;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    acc <= acc_next;
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                    if (is_div) begin
                        if (b_zero) begin
                            hi       <= a_orig;
                            lo       <= '1;
                            div_zero <= 1'b1;
                        end else begin
                            hi <= rem_fix;
                            lo <= quot_fix;
                        end
                    end else begin
                        {hi, lo} <= prod_fix;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit (WIDTH=32) with an expected-result queue and a done monitor.
module tb_md_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         div_zero;

    // {div_zero, hi, lo}
    logic [2*W:0] exp_q[$];
    int           start_q[$];
    int           cyc = 0;
    int           n_vec = 0;
    int           n_fail = 0;

    md_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo),
        .div_zero (div_zero)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse is compared against the oldest expectation
    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1, expected no done at cycle %0d", cyc);
            end else begin
                logic [2*W:0] e;
                int           s;
                e = exp_q.pop_front();
                s = (start_q.size() != 0) ? start_q.pop_front() : -1000;
                check("hi", 64'(hi), 64'(e[2*W-1:W]));
                check("lo", 64'(lo), 64'(e[W-1:0]));
                check("div_zero", 64'(div_zero), 64'(e[2*W]));
                check("busy_in_done", 64'(busy), 64'd0);
                check("latency", 64'(cyc - s), 64'd33);
            end
        end
    end

    // Drive one request; E0 is the next rising edge
    task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] eh, input logic [W-1:0] el, input logic ez,
                         input bit expect_it);
        @(negedge clk);
        op = o;
        a = x;
        b = y;
        start = 1'b1;
        if (expect_it) exp_q.push_back({ez, eh, el});
        @(negedge clk);
        start = 1'b0;
        if (expect_it) start_q.push_back(cyc);
        a = $urandom;
        b = $urandom;
        op = 2'($urandom_range(0, 3));
        check("busy_after_start", 64'(busy), 64'd1);
        check("div_zero_cleared", 64'(div_zero), 64'd0);
    endtask

    // Wait for all outstanding results, bounded
    task automatic wait_all();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL timeout: got %0d pending results, expected 0", exp_q.size());
            exp_q.delete();
            start_q.delete();
        end
        @(negedge clk);
    endtask

    // Poll for the next done pulse, returning its cycle
    task automatic wait_done(output int c);
        bit found;
        found = 0;
        c = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) begin
                c = cyc;
                found = 1;
                break;
            end
        end
        if (!found) begin
            n_vec++;
            n_fail++;
            $display("FAIL done_timeout: got no done, expected one within 100 cycles");
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d1;
        int d2;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_div_zero", 64'(div_zero), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Multiply vectors
        issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1); wait_all();
        issue(2'b01, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1); wait_all();
        issue(2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 1); wait_all();
        issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 1); wait_all();

        // Divide vectors
        issue(2'b11, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1); wait_all();
        issue(2'b11, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 1); wait_all();
        issue(2'b10, 32'd7,        32'd2,        32'h00000001, 32'h00000003, 1'b0, 1); wait_all();

        // Divide by zero, flag held, then cleared by the next start
        issue(2'b10, 32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, 1'b1, 1); wait_all();
        repeat (3) @(negedge clk);
        check("div_zero_held", 64'(div_zero), 64'd1);
        issue(2'b00, 32'd5,        32'd6,        32'h00000000, 32'd30,       1'b0, 1); wait_all();
        issue(2'b11, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1, 1); wait_all();
        issue(2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 1); wait_all();

        // start held through busy with changing operands: exactly one result
        @(negedge clk);
        op = 2'b00;
        a = 32'd2;
        b = 32'd3;
        start = 1'b1;
        exp_q.push_back({1'b0, 32'd0, 32'd6});
        @(negedge clk);
        start_q.push_back(cyc);
        repeat (25) begin
            @(negedge clk);
            a = $urandom;
            b = $urandom;
            op = 2'($urandom_range(0, 3));
        end
        start = 1'b0;
        wait_all();
        repeat (40) @(negedge clk);

        // Back-to-back: start accepted in the done cycle
        issue(2'b00, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 1);
        wait_done(d1);
        op = 2'b00;
        a = 32'd4;
        b = 32'd5;
        start = 1'b1;
        exp_q.push_back({1'b0, 32'd0, 32'd20});
        @(negedge clk);
        start = 1'b0;
        start_q.push_back(cyc);
        wait_done(d2);
        check("back_to_back_spacing", 64'(d2 - d1), 64'd34);
        wait_all();

        // Reset in the middle of a DIVU
        issue(2'b10, 32'd1000, 32'd7, 32'd0, 32'd0, 1'b0, 0);
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_hi", 64'(hi), 64'd0);
        check("abort_lo", 64'(lo), 64'd0);
        check("abort_div_zero", 64'(div_zero), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);

        // Normal operation after the abort
        issue(2'b10, 32'd1000, 32'd7, 32'd6, 32'd142, 1'b0, 1); wait_all();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
